// File: rtl/write_fifo_status_ctrl_if.sv
// Handshake bundle between the write-FIFO status controller and its surroundings
// (FIFO level and frame flags in, burst/tail requests and completion pulses out).
interface write_fifo_status_ctrl_if #(
  parameter int LSIZE = 9
);
  logic             enable;
  logic [9:0]       count;
  logic             fsync;
  logic             tail_status;
  logic             resp;
  logic             done;
  logic             burst_req;
  logic             tail_req;
  logic [LSIZE-1:0] req_len;
  logic             burst_done;
  logic             tail_done;
  logic             frame_done;
  logic             overflow;

  modport master (
    output enable, count, fsync, tail_status, resp, done,
    input  burst_req, tail_req, req_len, burst_done, tail_done, frame_done, overflow
  );

  modport slave (
    input  enable, count, fsync, tail_status, resp, done,
    output burst_req, tail_req, req_len, burst_done, tail_done, frame_done, overflow
  );
endinterface

// File: rtl/write_fifo_status_ctrl.sv
// Write-FIFO status controller: requests fixed bursts toward the AXI write master,
// one tail request per frame, and sequences the frame-start address reset.
module write_fifo_status_ctrl #(
  parameter int THRESHOLD = 128,
  parameter int FULL_LEN  = 256,
  parameter int LSIZE     = 9,
  parameter int RST_WAIT  = 31
) (
  input logic                   clock,
  input logic                   rst_n,
  write_fifo_status_ctrl_if.slave bus
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] W_A_RST   = 4'd1;
  localparam logic [3:0] NEED_WR   = 4'd2;
  localparam logic [3:0] WAIT_DONE = 4'd3;
  localparam logic [3:0] WR_FSH    = 4'd4;
  localparam logic [3:0] WR_TAIL   = 4'd5;
  localparam logic [3:0] W_T_DONE  = 4'd6;
  localparam logic [3:0] TAIL_FSH  = 4'd7;
  localparam logic [3:0] FRAME_END = 4'd8;

  localparam int               RW        = $clog2(RST_WAIT + 2);
  localparam logic [RW-1:0]    RCNT_MAX  = RW'(RST_WAIT);
  localparam logic [9:0]       THR_CNT   = 10'(THRESHOLD);
  localparam logic [9:0]       FULL_CNT  = 10'(FULL_LEN);
  localparam logic [LSIZE-1:0] BURST_LEN = LSIZE'(THRESHOLD);

  logic [3:0]    cstate;
  logic [3:0]    nstate;
  logic [RW-1:0] rcnt;
  logic          trig_full;
  logic          trig_tail;
  logic          fsync_pend;
  logic          frame_issued;
  logic          enter_rst;

  // A pending frame start beats any new request; full bursts beat the tail.
  always_comb begin
    nstate = cstate;
    case (cstate)
      IDLE: begin
        if (bus.fsync || fsync_pend)
          nstate = W_A_RST;
        else if (trig_full)
          nstate = NEED_WR;
        else if (trig_tail && !frame_issued)
          nstate = (bus.count != 10'd0) ? WR_TAIL : FRAME_END;
      end
      W_A_RST:   if (!bus.fsync && (rcnt > RCNT_MAX)) nstate = IDLE;
      NEED_WR:   if (bus.resp) nstate = WAIT_DONE;
      WAIT_DONE: if (bus.done) nstate = WR_FSH;
      WR_FSH:    nstate = IDLE;
      WR_TAIL:   if (bus.resp) nstate = W_T_DONE;
      W_T_DONE:  if (bus.done) nstate = TAIL_FSH;
      TAIL_FSH:  nstate = FRAME_END;
      FRAME_END: nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  assign enter_rst = (nstate == W_A_RST) && (cstate != W_A_RST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cstate       <= IDLE;
      rcnt         <= '0;
      trig_full    <= 1'b0;
      trig_tail    <= 1'b0;
      fsync_pend   <= 1'b0;
      frame_issued <= 1'b0;
    end else begin
      cstate    <= nstate;
      trig_full <= bus.enable && (bus.count >= THR_CNT);
      trig_tail <= bus.enable && bus.tail_status && (bus.count < THR_CNT);

      if (enter_rst)
        rcnt <= '0;
      else if ((cstate == W_A_RST) && !bus.fsync)
        rcnt <= rcnt + 1'b1;

      // Frame starts seen mid-request are deferred until the controller is idle.
      if (enter_rst)
        fsync_pend <= 1'b0;
      else if (bus.fsync && (cstate != IDLE) && (cstate != W_A_RST))
        fsync_pend <= 1'b1;

      if (cstate == W_A_RST)
        frame_issued <= 1'b0;
      else if (cstate == FRAME_END)
        frame_issued <= 1'b1;
    end
  end

  // Outputs decode the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.burst_req  <= 1'b0;
      bus.tail_req   <= 1'b0;
      bus.req_len    <= '0;
      bus.burst_done <= 1'b0;
      bus.tail_done  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.burst_req  <= (nstate == NEED_WR);
      bus.tail_req   <= (nstate == WR_TAIL);
      bus.burst_done <= (nstate == WR_FSH);
      bus.tail_done  <= (nstate == TAIL_FSH);
      bus.frame_done <= (nstate == FRAME_END);

      if (nstate == NEED_WR)
        bus.req_len <= BURST_LEN;
      else if ((nstate == WR_TAIL) && (cstate != WR_TAIL))
        bus.req_len <= bus.count[LSIZE-1:0];

      if (enter_rst)
        bus.overflow <= 1'b0;
      else if (bus.enable && (bus.count >= FULL_CNT))
        bus.overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_write_fifo_status_ctrl.sv
// Scoreboard bench for write_fifo_status_ctrl: directed stimulus queues expected
// request/completion events, a negedge monitor pops and compares them.
module tb_write_fifo_status_ctrl;

  localparam int K_BREQ  = 0;
  localparam int K_TREQ  = 1;
  localparam int K_BDONE = 2;
  localparam int K_TDONE = 3;
  localparam int K_FDONE = 4;

  typedef struct {
    int kind;
    int len;
  } ev_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc;
  ev_t  exp_q[$];
  logic prev_breq = 1'b0;
  logic prev_treq = 1'b0;

  write_fifo_status_ctrl_if #(.LSIZE(9)) bus ();

  write_fifo_status_ctrl #(
    .THRESHOLD(128),
    .FULL_LEN (256),
    .LSIZE    (9),
    .RST_WAIT (31)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic push_ev(input int kind, input int len);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic observe(input int kind, input int len);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_event: got kind=%0d len=%0d, want none", kind, len);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != kind) || (e.len != len)) begin
        bad++;
        $display("[TB] FAIL event: got kind=%0d len=%0d, want kind=%0d len=%0d",
                 kind, len, e.kind, e.len);
      end
    end
  endtask

  // Every rising request and every completion pulse must match the next queued event.
  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.burst_req && !prev_breq) observe(K_BREQ, int'(bus.req_len));
      if (bus.tail_req && !prev_treq)  observe(K_TREQ, int'(bus.req_len));
      if (bus.burst_done)              observe(K_BDONE, 0);
      if (bus.tail_done)               observe(K_TDONE, 0);
      if (bus.frame_done)              observe(K_FDONE, 0);
    end
    prev_breq = bus.burst_req;
    prev_treq = bus.tail_req;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [9:0] cnt,
                                input logic ts, input logic fs);
    bus.enable      = en;
    bus.count       = cnt;
    bus.tail_status = ts;
    bus.fsync       = fs;
  endtask

  function automatic logic sig_now(input int which);
    case (which)
      K_BREQ:  return bus.burst_req;
      K_TREQ:  return bus.tail_req;
      K_BDONE: return bus.burst_done;
      K_TDONE: return bus.tail_done;
      default: return bus.frame_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int cycles);
    cycles = 0;
    while (!sig_now(which) && (cycles < limit)) begin
      tick(1);
      cycles++;
    end
    if (!sig_now(which)) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_timeout: got no event kind=%0d after %0d cycles, want event", which, cycles);
    end
  endtask

  task automatic serve_resp();
    bus.resp = 1'b1;
    tick(1);
    bus.resp = 1'b0;
    check_output("req_drop", int'(bus.burst_req | bus.tail_req), 0);
  endtask

  task automatic serve_done();
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
  endtask

  task automatic serve_overlap(input int done_kind);
    int c;
    bus.resp = 1'b1;
    bus.done = 1'b1;
    tick(1);
    bus.resp = 1'b0;
    check_output("req_drop_overlap", int'(bus.burst_req | bus.tail_req), 0);
    wait_sig(done_kind, 10, c);
    bus.done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_burst_req"},  int'(bus.burst_req),  0);
    check_output({tag, "_tail_req"},   int'(bus.tail_req),   0);
    check_output({tag, "_req_len"},    int'(bus.req_len),    0);
    check_output({tag, "_burst_done"}, int'(bus.burst_done), 0);
    check_output({tag, "_tail_done"},  int'(bus.tail_done),  0);
    check_output({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check_output({tag, "_overflow"},   int'(bus.overflow),   0);
  endtask

  initial begin
    apply_stimulus(1'b0, 10'd0, 1'b0, 1'b0);
    bus.resp = 1'b0;
    bus.done = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Full bursts, then a back-to-back re-trigger while the FIFO stays above threshold.
    apply_stimulus(1'b1, 10'd100, 1'b0, 1'b0);
    tick(5);
    push_ev(K_BREQ, 128);
    apply_stimulus(1'b1, 10'd128, 1'b0, 1'b0);
    wait_sig(K_BREQ, 20, cyc);
    check_output("burst_latency", cyc, 2);
    apply_stimulus(1'b1, 10'd200, 1'b0, 1'b0);
    serve_resp();
    push_ev(K_BDONE, 0);
    push_ev(K_BREQ, 128);
    serve_done();
    wait_sig(K_BREQ, 20, cyc);
    check_output("rearm_latency", cyc, 2);
    push_ev(K_BDONE, 0);
    apply_stimulus(1'b1, 10'd50, 1'b0, 1'b0);
    serve_overlap(K_BDONE);
    tick(5);

    // Tail of 37 words, then no second tail while tail_status stays high.
    push_ev(K_TREQ, 37);
    push_ev(K_TDONE, 0);
    push_ev(K_FDONE, 0);
    apply_stimulus(1'b1, 10'd37, 1'b1, 1'b0);
    wait_sig(K_TREQ, 20, cyc);
    serve_resp();
    serve_done();
    wait_sig(K_FDONE, 10, cyc);
    check_output("frame_after_tail", cyc, 1);
    tick(10);
    apply_stimulus(1'b1, 10'd37, 1'b0, 1'b0);

    // New frame, then an empty tail that only produces frame_done.
    apply_stimulus(1'b1, 10'd50, 1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 10'd50, 1'b0, 1'b0);
    tick(40);
    push_ev(K_FDONE, 0);
    apply_stimulus(1'b1, 10'd0, 1'b1, 1'b0);
    wait_sig(K_FDONE, 20, cyc);
    check_output("empty_tail_latency", cyc, 2);
    tick(5);
    apply_stimulus(1'b1, 10'd0, 1'b0, 1'b0);
    tick(2);

    // Overflow plus fsync during WAIT_DONE: burst completes, then the address-reset wait.
    push_ev(K_BREQ, 128);
    apply_stimulus(1'b1, 10'd256, 1'b0, 1'b0);
    wait_sig(K_BREQ, 20, cyc);
    check_output("overflow_set", int'(bus.overflow), 1);
    apply_stimulus(1'b1, 10'd200, 1'b0, 1'b0);
    serve_resp();
    apply_stimulus(1'b1, 10'd200, 1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 10'd200, 1'b0, 1'b0);
    push_ev(K_BDONE, 0);
    push_ev(K_BREQ, 128);
    serve_done();
    check_output("overflow_sticky", int'(bus.overflow), 1);
    wait_sig(K_BREQ, 60, cyc);
    check_output("addr_rst_wait", cyc, 36);
    check_output("overflow_clear", int'(bus.overflow), 0);
    push_ev(K_BDONE, 0);
    apply_stimulus(1'b1, 10'd20, 1'b0, 1'b0);
    serve_resp();
    serve_done();
    tick(3);

    // Tail is allowed again after the frame start cleared the per-frame flag.
    push_ev(K_TREQ, 20);
    push_ev(K_TDONE, 0);
    push_ev(K_FDONE, 0);
    apply_stimulus(1'b1, 10'd20, 1'b1, 1'b0);
    wait_sig(K_TREQ, 20, cyc);
    serve_overlap(K_TDONE);
    wait_sig(K_FDONE, 10, cyc);
    tick(5);
    apply_stimulus(1'b1, 10'd20, 1'b0, 1'b0);
    tick(2);

    // Asynchronous reset in WAIT_DONE, then enable gating after release.
    push_ev(K_BREQ, 128);
    apply_stimulus(1'b1, 10'd128, 1'b0, 1'b0);
    wait_sig(K_BREQ, 20, cyc);
    apply_stimulus(1'b1, 10'd0, 1'b0, 1'b0);
    serve_resp();
    check_output("len_before_reset", int'(bus.req_len), 128);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    apply_stimulus(1'b0, 10'd200, 1'b0, 1'b0);
    tick(6);
    push_ev(K_BREQ, 128);
    apply_stimulus(1'b1, 10'd200, 1'b0, 1'b0);
    wait_sig(K_BREQ, 20, cyc);
    check_output("post_reset_latency", cyc, 2);
    apply_stimulus(1'b1, 10'd0, 1'b0, 1'b0);
    serve_resp();
    push_ev(K_BDONE, 0);
    serve_done();
    tick(5);

    check_output("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_fifo_status_ctrl.md
Name: write_fifo_status_ctrl

Overview:
Write-side counterpart of the VDMA read-FIFO controller. Watches the fill level of the write FIFO, which is loaded by the video input and drained to DDR by the AXI write master. Issues fixed-length burst requests once enough data is buffered. At end of frame, issues one tail request for the leftover words. Sequences the frame-start address reset and the end-of-frame completion toward the write master.

Parameters:
THRESHOLD, 128, full-burst length in FIFO words; a burst is requested when count >= THRESHOLD
FULL_LEN, 256, FIFO depth in words; used for overflow detection
LSIZE, 9, width of req_len and tail length
RST_WAIT, 31, address-reset wait; W_A_RST is held until rcnt > RST_WAIT

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  channel enable; gates burst and tail triggers
count  in  10  current write-FIFO word count
fsync  in  1  frame start (level or pulse, clock domain)
tail_status  in  1  input frame fully pushed into FIFO; remaining words form the tail
resp  in  1  write master accepted current request
done  in  1  write master finished current request (last BRESP)
burst_req  out  1  full-burst request, level until resp
tail_req  out  1  tail request, level until resp
req_len  out  LSIZE  length of current request
burst_done  out  1  one-cycle pulse after full burst completes
tail_done  out  1  one-cycle pulse after tail completes
frame_done  out  1  one-cycle pulse when frame fully written (with or without tail)
overflow  out  1  sticky: count reached FULL_LEN while enabled; cleared on fsync

Behaviour:
- Reset: state IDLE; all outputs 0; req_len 0; rcnt 0; fsync_pend 0; trig_full 0; trig_tail 0.
- Registered triggers, one cycle of latency:
  - trig_full <= enable && count >= THRESHOLD.
  - trig_tail <= enable && tail_status && count < THRESHOLD.
- State register cstate <= nstate. All outputs are registered, decoded from nstate, and become valid in the same cycle cstate enters the state.
- IDLE:
  - fsync || fsync_pend -> W_A_RST.
  - Else trig_full -> NEED_WR.
  - Else trig_tail: count != 0 -> WR_TAIL; count == 0 -> FRAME_END.
  - Else stay in IDLE.
- W_A_RST:
  - rcnt increments each cycle fsync is low; rcnt holds while fsync is high.
  - Exit to IDLE when rcnt > RST_WAIT with fsync low.
  - Entering W_A_RST clears fsync_pend and overflow.
- NEED_WR: burst_req=1, req_len<=THRESHOLD. resp -> WAIT_DONE. req drops on the cycle after resp.
- WAIT_DONE: done -> WR_FSH.
- WR_FSH: burst_done=1 for one cycle -> IDLE. A FIFO still >= THRESHOLD re-triggers back-to-back bursts.
- WR_TAIL:
  - On entry, req_len <= count[LSIZE-1:0], latched once and held.
  - tail_req=1. resp -> W_T_DONE.
- W_T_DONE: done -> TAIL_FSH.
- TAIL_FSH: tail_done=1 -> FRAME_END.
- FRAME_END: frame_done=1 for one cycle -> IDLE.
- Ordering rule: full bursts always take priority over the tail. The tail is only issued when count < THRESHOLD.
- At most one tail/frame_done per frame:
  - A frame_issued flag sets in FRAME_END and clears in W_A_RST.
  - trig_tail is ignored while the flag is set.
- fsync outside IDLE/W_A_RST sets fsync_pend. The in-flight request is never aborted; W_A_RST is taken at the next IDLE.
- resp and done in the same cycle are legal: resp is taken first, and done is then sampled in the WAIT_DONE/W_T_DONE cycle. The master holds done as a level until the done pulse is seen, or pulses it after resp only.
- done without a prior resp is ignored.
- overflow sets when enable && count >= FULL_LEN. It is sticky until W_A_RST.
- enable low in IDLE: no new requests; fsync is still honoured. enable low mid-request: the request completes normally.
- Illegal state encodings -> IDLE.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_DONE -> all outputs 0 immediately; after release, IDLE with no request until a trigger.
- Full burst: THRESHOLD=128, count steps 100->128 -> burst_req rises 2 cycles later, req_len=128; resp -> burst_req falls next cycle; done -> burst_done single pulse; count held 200 -> second burst_req follows.
- Tail: tail_status=1, count=37 -> tail_req with req_len=37; resp, done -> tail_done pulse, then frame_done pulse next cycle; no further tail_req while tail_status stays 1.
- Empty tail: tail_status=1, count=0 -> frame_done pulse, no tail_req.
- fsync during WAIT_DONE -> burst completes, burst_done pulses, then W_A_RST for 33 fsync-low cycles, during which count=200 raises no burst_req; overflow and frame_issued cleared.
- Overflow: count=256 with enable=1 -> overflow=1, stays set through bursts, clears after next fsync.
